// File: rtl/nic_core_pkg.sv
// nic_core_pkg: opcodes, register codes and FSM states shared by
// the nic_core accumulator CPU and its ALU.
package nic_core_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_MOV = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_JC  = 4'h9;
   localparam logic [3:0] OP_OUT = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] REG_A = 2'd0;
   localparam logic [1:0] REG_B = 2'd1;
   localparam logic [1:0] REG_X = 2'd2;
   localparam logic [1:0] REG_Q = 2'd3;

   typedef enum logic [2:0] {
      FETCH,
      EXEC,
      IMM,
      MEM,
      HALT
   } state_t;

endpackage

// File: rtl/nic_alu.sv
// nic_alu: WIDTH-bit add/subtract for the accumulator.
// Ports: a, b operands; sub selects a-b; result, carry, aIsZero.
module nic_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             aIsZero
);

   logic [WIDTH:0] sum;

   always_comb begin
      if (sub) sum = {1'b0, a} - {1'b0, b};
      else     sum = {1'b0, a} + {1'b0, b};
   end

   assign result  = sum[WIDTH-1:0];
   // a borrow sets the top bit, so "no borrow" means a >= b
   assign carry   = sub ? ~sum[WIDTH] : sum[WIDTH];
   assign aIsZero = (a == '0);

endmodule

// File: rtl/nic_core.sv
// nic_core: multicycle accumulator CPU on one ready-handshake port.
// Ports: clk, reset (async, low); mem_* bus; pc/ir/regs debug; halted.
module nic_core
   import nic_core_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ADDR  = 8
) (
   input  logic             clk,
   input  logic             reset,
   output logic [ADDR-1:0]  mem_addr,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [ADDR-1:0]  pc,
   output logic [WIDTH-1:0] ir,
   output logic [WIDTH-1:0] areg,
   output logic [WIDTH-1:0] breg,
   output logic [WIDTH-1:0] xreg,
   output logic [WIDTH-1:0] qreg,
   output logic             halted
);

   state_t           state;
   logic [WIDTH-1:0] regs [4];
   logic             carry;
   logic [3:0]       op;
   logic [1:0]       rSel;
   logic [1:0]       dSel;
   logic [WIDTH-1:0] aluRes;
   logic             aluCarry;
   logic             aIsZero;
   logic             isImmOp;
   logic             isMemOp;
   logic             taken;
   logic [ADDR-1:0]  pcInc;
   logic [ADDR-1:0]  immPc;
   logic [ADDR-1:0]  dataAddr;

   assign op       = ir[7:4];
   assign rSel     = ir[1:0];
   assign dSel     = ir[3:2];
   assign pcInc    = pc + ADDR'(1);
   assign dataAddr = regs[REG_X][ADDR-1:0];
   assign isImmOp  = op inside {OP_LDI, OP_JMP, OP_JZ, OP_JC};
   assign isMemOp  = op inside {OP_LD, OP_ST};

   assign taken = (op == OP_JMP)
                | ((op == OP_JZ) & aIsZero)
                | ((op == OP_JC) & carry);

   // LDI is never "taken", so it simply steps past its immediate
   assign immPc = taken ? mem_rdata[ADDR-1:0] : pcInc;

   assign areg = regs[REG_A];
   assign breg = regs[REG_B];
   assign xreg = regs[REG_X];
   assign qreg = regs[REG_Q];

   nic_alu #(.WIDTH(WIDTH)) alu (
      .a       (regs[REG_A]),
      .b       (regs[REG_B]),
      .sub     (op == OP_SUB),
      .result  (aluRes),
      .carry   (aluCarry),
      .aIsZero (aIsZero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH;
         pc        <= '0;
         ir        <= '0;
         carry     <= 1'b0;
         halted    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (!mem_req) begin
                  // first cycle after reset: raise the fetch
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pcInc;
                  mem_req <= 1'b0;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               unique case (1'b1)
                  isImmOp: begin
                     state    <= IMM;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                  end
                  isMemOp: begin
                     state     <= MEM;
                     mem_req   <= 1'b1;
                     mem_we    <= (op == OP_ST);
                     mem_addr  <= dataAddr;
                     mem_wdata <= regs[rSel];
                  end
                  (op == OP_HLT): begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
                  default: begin
                     state    <= FETCH;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                     case (op)
                        OP_ADD, OP_SUB: begin
                           regs[REG_A] <= aluRes;
                           carry       <= aluCarry;
                        end
                        OP_MOV:  regs[dSel]  <= regs[rSel];
                        OP_OUT:  regs[REG_Q] <= regs[REG_A];
                        OP_NOP:  ;
                        default: ;
                     endcase
                  end
               endcase
            end
            IMM: begin
               if (mem_ready) begin
                  if (op == OP_LDI) regs[rSel] <= mem_rdata;
                  pc       <= immPc;
                  mem_addr <= immPc;
                  state    <= FETCH;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  if (!mem_we) regs[rSel] <= mem_rdata;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= FETCH;
               end
            end
            HALT: ;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: doc/nic_core.md
# nic_core

Parametrised successor to the nic8 whole-CPU top. It is a multicycle accumulator CPU of WIDTH-bit data and ADDR-bit address, driven by an explicit fetch/execute state machine. It uses a single unified memory port with a ready/wait-state handshake in place of separate zero-latency ROM/RAM. The block sits between the testbench/SoC memory model and the debug outputs (pc, ir, registers) used by the existing waveform viewers.

## Interface
- WIDTH, 8: data/register width; must be ≥ 8 (opcode occupies low 8 bits of a fetched word).
- ADDR, 8: address width; pc and memory address are ADDR bits.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
- mem_addr  out  ADDR  memory address, valid while mem_req=1.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data, sampled on the edge where mem_ready=1.
- mem_ready  in  1  access completes on any edge with mem_req=1 and mem_ready=1.
- pc, ir, areg, breg, xreg, qreg  out  ADDR/WIDTH  debug views of architectural registers.
- halted  out  1  high in HALT state.

## Operation
- Registers: A, B, X, Q (code 0..3), pc, ir, carry flag.
- Opcode = ir[7:4], fields r = ir[1:0], d = ir[3:2].
  - 0 NOP. 1 LDI r,#imm (two-word). 2 LD r,[X]. 3 ST r,[X].
  - 4 ADD: A ← A+B, carry = carry-out. 5 SUB: A ← A−B, carry = (A ≥ B unsigned).
  - 6 MOV d ← r. 7 JMP #imm. 8 JZ #imm (taken iff A = 0). 9 JC #imm (taken iff carry).
  - A OUT: Q ← A. F HLT. All others execute as NOP.
- Arithmetic is modulo 2^WIDTH. Only ADD/SUB write carry.
- Data address = X[ADDR-1:0]. Immediates and jump targets use the low ADDR bits for pc.
- pc increments modulo 2^ADDR: 2^ADDR−1 wraps to 0.
- Not-taken JZ/JC still consumes the immediate word (pc += 1 past it).
- States:
  - FETCH: read mem[pc]. On ready, ir ← rdata, pc ← pc+1, go to EXEC.
  - EXEC: single-word ops complete here and go to FETCH. LDI/JMP/JZ/JC go to IMM. LD/ST go to MEM. HLT goes to HALT.
  - IMM: read mem[pc]. On ready, either reg r ← rdata with pc ← pc+1, or pc ← target (taken) / pc+1 (not taken). Go to FETCH.
  - MEM: LD reads mem[X] into r; ST writes r to mem[X]. On ready, go to FETCH.
  - HALT: no requests; left only by reset.
- mem_req = 1 exactly in FETCH, IMM, MEM and while reset is deasserted. mem_we = 1 only in MEM for ST.
- mem_addr and mem_wdata are held stable until ready.

## Timing
- Reset value of all outputs: pc, ir, A, B, X, Q, carry = 0; state FETCH; mem_req = 0; halted = 0.
- First fetch request is at address 0 on the first edge after reset release.
- Zero-wait latency (ready tied high):
  - NOP, ADD, SUB, MOV, OUT: 2 cycles.
  - LDI, JMP, JZ, JC, LD, ST: 3 cycles.
  - Each low cycle of mem_ready adds one cycle.
- Register and flag results are visible on the debug outputs the cycle after the completing edge.
- JZ tests A as it stands in IMM. A value written by the previous instruction is already visible.
- Reset asserted mid-access drops mem_req asynchronously. The pending access is abandoned, with no register update.
- mem_ready while mem_req = 0 is ignored.

## Structure
- Package nic_core_pkg holds:
  - opcode localparams
  - register codes
  - state enum (FETCH, EXEC, IMM, MEM, HALT)
- One sub-module, nic_alu: WIDTH-parametrised add/sub, producing the result, carry and aIsZero combinationally.
- The state machine, register file and bus muxing live in nic_core.

## Test plan
- Reset/first fetch: hold reset=0 for 3 cycles, release → mem_req=1, mem_addr=0, all registers 0, halted=0.
- Arithmetic: LDI A,#0xF0; LDI B,#0x20; ADD; OUT; HLT (ready=1) → qreg=0x10, carry=1, halted=1 after 13 cycles.
- Branches: LDI A,#0; JZ #0x40 → pc=0x40. With A=1, JZ instead → pc = address after the immediate. SUB 5−7 → carry=0, so JC is not taken.
- Wait states: ST with mem_ready low for 3 cycles → mem_addr, mem_we=1 and mem_wdata stable all 4 cycles. Exactly one write, then FETCH.
- Wrap and params: WIDTH=16, ADDR=4, NOP at 0xF → next fetch at 0x0. ADD 0xFFFF+0x0001 → A=0, carry=1.
- Mid-access reset: reset=0 during a stalled LD → mem_req=0 immediately, target register unchanged, restart at pc 0.
